// File: rtl/oled_pkg.sv
// ---------------------------------------------------------------------------
// oled_pkg
// Shared definitions for the 96x64 RGB565 Pmod OLED scan engine:
//   - SSD1331-style window command opcodes sent ahead of every frame
//   - scan FSM state encoding
//   - common RGB565 colours used by the pixel generators
//   - preamble ROM lookup
// ---------------------------------------------------------------------------
package oled_pkg;

    localparam logic [7:0] CMD_SET_COL = 8'h15;
    localparam logic [7:0] CMD_SET_ROW = 8'h75;

    localparam logic [15:0] RGB565_ORANGE = 16'hFDA0;
    localparam logic [15:0] RGB565_BLACK  = 16'h0000;

    localparam int PREAMBLE_LEN = 6;

    // The "what comes next" decision after a transfer has no cycle of its
    // own; it is taken in the final SHIFT cycle, so it has no state here.
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP
    } oled_state_t;

    // Column window 0..last_col, then row window 0..last_row.
    function automatic logic [7:0] preamble_byte(input logic [2:0] idx,
                                                 input logic [7:0] last_col,
                                                 input logic [7:0] last_row);
        logic [7:0] b;
        case (idx)
            3'd0:    b = CMD_SET_COL;
            3'd1:    b = 8'h00;
            3'd2:    b = last_col;
            3'd3:    b = CMD_SET_ROW;
            3'd4:    b = 8'h00;
            default: b = last_row;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/oled_spi_shifter.sv
// ---------------------------------------------------------------------------
// oled_spi_shifter
// Write-only SPI mode-0 serialiser, MSB first, 8- or 16-bit transfers.
// Each bit occupies 2*CLK_DIV clk cycles: sclk low for the first CLK_DIV,
// high for the last CLK_DIV. sdin is updated together with the falling
// sclk edge (or on load), so it is stable for the whole bit.
//
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   load        start a transfer with data/wide (ignored otherwise)
//   wide        1 = 16-bit transfer of data[15:0], 0 = 8-bit of data[15:8]
//   data        transfer payload, left-aligned
//   sclk, sdin  SPI clock and data
//   done        high during the final cycle of the transfer
// ---------------------------------------------------------------------------
module oled_spi_shifter #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        wide,
    input  logic [15:0] data,
    output logic        sclk,
    output logic        sdin,
    output logic        done
);

    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic             active;
    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       bit_cnt;
    logic [3:0]       last_bit;
    // Bit 15 of the payload goes straight to sdin at load, so only the
    // remaining 15 bits need to be held.
    logic [14:0]      shreg;
    logic             bit_end;

    always_comb begin
        bit_end = active && sclk && (div_cnt == DIV_LAST);
        done    = bit_end && (bit_cnt == last_bit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            active   <= 1'b0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            last_bit <= '0;
            sclk     <= 1'b0;
            sdin     <= 1'b0;
        end else if (load) begin
            active   <= 1'b1;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            last_bit <= wide ? 4'd15 : 4'd7;
            sclk     <= 1'b0;
            sdin     <= data[15];
        end else if (active) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                if (!sclk) begin
                    sclk <= 1'b1;
                end else begin
                    sclk <= 1'b0;
                    if (bit_cnt == last_bit) begin
                        active <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                        sdin    <= shreg[14];
                    end
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

    // Payload register carries no reset; it is always reloaded before use.
    always_ff @(posedge clk) begin
        if (load) begin
            shreg <= data[14:0];
        end else if (bit_end) begin
            shreg <= {shreg[13:0], 1'b0};
        end
    end

endmodule

// File: rtl/oled_frame_streamer.sv
// ---------------------------------------------------------------------------
// oled_frame_streamer
// Raster scan engine for the 96x64 RGB565 Pmod OLED. Each frame sends a
// 6-byte column/row window preamble (dc=0) followed by WIDTH*HEIGHT
// RGB565 words (dc=1), then holds cs_n high for GAP_CYCLES.
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   enable       run frames while high; a started frame always completes
//   pixel_data   colour for the current px/py, sampled in the second LOAD
//                cycle of each pixel word only
//   px, py       current scan coordinate, driven to the pixel generators
//   frame_begin  one-cycle pulse in the first cycle of each frame
//   busy         high from frame start until the end of its gap
//   cs_n, sclk, sdin, dc   SPI mode-0 panel interface
// ---------------------------------------------------------------------------
module oled_frame_streamer #(
    parameter int WIDTH      = 96,
    parameter int HEIGHT     = 64,
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] pixel_data,
    output logic [6:0]  px,
    output logic [6:0]  py,
    output logic        frame_begin,
    output logic        busy,
    output logic        cs_n,
    output logic        sclk,
    output logic        sdin,
    output logic        dc
);

    import oled_pkg::*;

    localparam int               GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
    localparam logic [6:0]       LAST_PX  = 7'(WIDTH - 1);
    localparam logic [6:0]       LAST_PY  = 7'(HEIGHT - 1);
    localparam logic [2:0]       LAST_ROM = 3'(PREAMBLE_LEN - 1);

    oled_state_t      state;
    logic             load_phase;
    logic             in_preamble;
    logic [2:0]       rom_idx;
    logic [GAP_W-1:0] gap_cnt;

    logic             shift_load;
    logic             shift_wide;
    logic [15:0]      shift_data;
    logic             shift_done;
    logic [7:0]       rom_byte;
    logic             frame_start;

    always_comb begin
        rom_byte    = preamble_byte(rom_idx, 8'(WIDTH - 1), 8'(HEIGHT - 1));
        // The shifter captures on the second LOAD cycle, so the generators
        // get the whole first cycle to settle on the new px/py.
        shift_load  = (state == ST_LOAD) && load_phase;
        shift_wide  = !in_preamble;
        shift_data  = in_preamble ? {rom_byte, 8'h00} : pixel_data;
        frame_start = enable &&
                      ((state == ST_IDLE) ||
                       ((state == ST_GAP) && (gap_cnt == GAP_LAST)));
    end

    oled_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk   (clk),
        .reset (reset),
        .load  (shift_load),
        .wide  (shift_wide),
        .data  (shift_data),
        .sclk  (sclk),
        .sdin  (sdin),
        .done  (shift_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            load_phase  <= 1'b0;
            in_preamble <= 1'b1;
            rom_idx     <= '0;
            gap_cnt     <= '0;
            px          <= '0;
            py          <= '0;
            frame_begin <= 1'b0;
            busy        <= 1'b0;
            cs_n        <= 1'b1;
            dc          <= 1'b0;
        end else begin
            frame_begin <= 1'b0;
            if (frame_start) begin
                state       <= ST_LOAD;
                load_phase  <= 1'b0;
                in_preamble <= 1'b1;
                rom_idx     <= '0;
                px          <= '0;
                py          <= '0;
                frame_begin <= 1'b1;
                busy        <= 1'b1;
                cs_n        <= 1'b0;
                dc          <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                    end
                    ST_LOAD: begin
                        load_phase <= 1'b1;
                        if (load_phase) begin
                            state <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        // Next-transfer decision, taken in the last bit cycle.
                        if (shift_done) begin
                            if (in_preamble) begin
                                state      <= ST_LOAD;
                                load_phase <= 1'b0;
                                if (rom_idx == LAST_ROM) begin
                                    in_preamble <= 1'b0;
                                    dc          <= 1'b1;
                                end else begin
                                    rom_idx <= rom_idx + 3'd1;
                                end
                            end else if ((px == LAST_PX) && (py == LAST_PY)) begin
                                state   <= ST_GAP;
                                gap_cnt <= '0;
                                cs_n    <= 1'b1;
                                px      <= '0;
                                py      <= '0;
                            end else begin
                                state      <= ST_LOAD;
                                load_phase <= 1'b0;
                                if (px == LAST_PX) begin
                                    px <= '0;
                                    py <= py + 7'd1;
                                end else begin
                                    px <= px + 7'd1;
                                end
                            end
                        end
                    end
                    ST_GAP: begin
                        // Gap end with enable high is handled by frame_start.
                        if (gap_cnt == GAP_LAST) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
